frame_end_pulse_sequencer: RTL and testbench

FRAME_END_PULSE_SEQUENCER -- requirements
Module: frame_end_pulse_sequencer

---
 rtl/frame_end_pulse_sequencer.sv | 143 ++++++++++++++
 tb/tb_frame_end_pulse_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_end_pulse_sequencer.sv
// Per-channel end-of-frame sequencer: mass-reset pulse, idle gap, then a
// diode-request pulse, finished by a one-cycle done strobe.
`timescale 1ns/1ps
module frame_end_pulse_sequencer #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 9,
  parameter int RETRIG = 0
) (
  input  logic              clk_200MHz_i,
  input  logic              reset,
  input  logic [N_CH-1:0]   req_i,
  input  logic [CNT_W-1:0]  rst_len_i,
  input  logic [CNT_W-1:0]  gap_len_i,
  input  logic [CNT_W-1:0]  pulse_len_i,
  input  logic              clr_ovr_i,
  output logic [N_CH-1:0]   mass_reset_o,
  output logic [N_CH-1:0]   diode_req_o,
  output logic [N_CH-1:0]   done_o,
  output logic [N_CH-1:0]   busy_o,
  output logic [N_CH-1:0]   overrun_o,
  output logic              mass_reset_any_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_GAP   = 3'd2,
    S_PULSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_CH-1:0] mass_reset_d;
  logic            mass_reset_any_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic             ovr_q, ovr_d;
    logic             mass_reset_q, diode_req_q, done_q, busy_q;
    logic             active, accept;

    // The counter holds the cycles remaining after the current one, so a
    // phase of length N loads N-1 and ends when the counter reads zero.
    always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      pulse_d = pulse_q;
      ovr_d   = ovr_q & ~clr_ovr_i;
      active  = (state_q == S_RESET) || (state_q == S_GAP) || (state_q == S_PULSE);
      accept  = req_i[c] && (!active || (RETRIG != 0));

      if (accept) begin
        state_d = S_RESET;
        cnt_d   = (rst_len_i == '0) ? '0 : rst_len_i - CNT_ONE;
        gap_d   = gap_len_i;
        pulse_d = pulse_len_i;
      end else begin
        if (req_i[c] && active) ovr_d = 1'b1;
        case (state_q)
          S_RESET: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_ONE;
            end else if (gap_q != '0) begin
              state_d = S_GAP;
              cnt_d   = gap_q - CNT_ONE;
            end else if (pulse_q != '0) begin
              state_d = S_PULSE;
              cnt_d   = pulse_q - CNT_ONE;
            end else begin
              state_d = S_DONE;
            end
          end
          S_GAP: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_ONE;
            end else if (pulse_q != '0) begin
              state_d = S_PULSE;
              cnt_d   = pulse_q - CNT_ONE;
            end else begin
              state_d = S_DONE;
            end
          end
          S_PULSE: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
            else             state_d = S_DONE;
          end
          S_DONE:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Outputs are decoded from the next state and registered, so every
    // output toggles together with the state it reflects.
    always_ff @(posedge clk_200MHz_i or posedge reset) begin
      if (reset) begin
        state_q      <= S_IDLE;
        cnt_q        <= '0;
        gap_q        <= '0;
        pulse_q      <= '0;
        ovr_q        <= 1'b0;
        mass_reset_q <= 1'b0;
        diode_req_q  <= 1'b0;
        done_q       <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments make every flop see the pre-edge
        // values, independent of statement order.
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        gap_q        <= gap_d;
        pulse_q      <= pulse_d;
        ovr_q        <= ovr_d;
        mass_reset_q <= (state_d == S_RESET);
        diode_req_q  <= (state_d == S_PULSE);
        done_q       <= (state_d == S_DONE);
        busy_q       <= (state_d == S_RESET) || (state_d == S_GAP) || (state_d == S_PULSE);
      end
    end

    assign mass_reset_d[c] = (state_d == S_RESET);
    assign mass_reset_o[c] = mass_reset_q;
    assign diode_req_o[c]  = diode_req_q;
    assign done_o[c]       = done_q;
    assign busy_o[c]       = busy_q;
    assign overrun_o[c]    = ovr_q;
  end

  always_ff @(posedge clk_200MHz_i or posedge reset) begin
    if (reset) mass_reset_any_q <= 1'b0;
    else       mass_reset_any_q <= |mass_reset_d;
  end

  assign mass_reset_any_o = mass_reset_any_q;

endmodule

// File: tb/tb_frame_end_pulse_sequencer.sv
// Scoreboard bench: stimulus pushes expected pulses (start cycle, length);
// a negedge monitor measures every output pulse and retires the match.
`timescale 1ns/1ps
module tb_frame_end_pulse_sequencer;

  localparam int K_MR = 0, K_DR = 1, K_DONE = 2, K_BUSY = 3;

  typedef struct {
    int inst;
    int ch;
    int kind;
    int start;
    int len;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req0, req1;
  logic [8:0] rst_len, gap_len, pulse_len;
  logic       clr_ovr;
  logic [3:0] mr_w   [2];
  logic [3:0] dr_w   [2];
  logic [3:0] done_w [2];
  logic [3:0] busy_w [2];
  logic [3:0] ovr_w  [2];
  logic       any_w  [2];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic prev_v [2][4][4];
  int   st_v   [2][4][4];
  string kname [4] = '{"mass_reset", "diode_req", "done", "busy"};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_end_pulse_sequencer #(.N_CH(4), .CNT_W(9), .RETRIG(0)) u_dut0 (
    .clk_200MHz_i(clk), .reset(reset), .req_i(req0),
    .rst_len_i(rst_len), .gap_len_i(gap_len), .pulse_len_i(pulse_len),
    .clr_ovr_i(clr_ovr), .mass_reset_o(mr_w[0]), .diode_req_o(dr_w[0]),
    .done_o(done_w[0]), .busy_o(busy_w[0]), .overrun_o(ovr_w[0]),
    .mass_reset_any_o(any_w[0]));

  frame_end_pulse_sequencer #(.N_CH(4), .CNT_W(9), .RETRIG(1)) u_dut1 (
    .clk_200MHz_i(clk), .reset(reset), .req_i(req1),
    .rst_len_i(rst_len), .gap_len_i(gap_len), .pulse_len_i(pulse_len),
    .clr_ovr_i(clr_ovr), .mass_reset_o(mr_w[1]), .diode_req_o(dr_w[1]),
    .done_o(done_w[1]), .busy_o(busy_w[1]), .overrun_o(ovr_w[1]),
    .mass_reset_any_o(any_w[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int inst, input int ch, input int kind, input int start, input int len);
    exp_t e;
    e.inst = inst; e.ch = ch; e.kind = kind; e.start = start; e.len = len;
    exp_q.push_back(e);
  endtask

  function automatic logic [3:0] sig(input int i, input int k);
    case (k)
      K_MR:    return mr_w[i];
      K_DR:    return dr_w[i];
      K_DONE:  return done_w[i];
      default: return busy_w[i];
    endcase
  endfunction

  task automatic retire(input int i, input int c, input int k, input int st, input int ln);
    int idx = -1;
    foreach (exp_q[j])
      if (idx < 0 && exp_q[j].inst == i && exp_q[j].ch == c && exp_q[j].kind == k) idx = j;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL u%0d ch%0d %s unexpected pulse start=%0d len=%0d expected none",
               i, c, kname[k], st, ln);
    end else begin
      check($sformatf("u%0d ch%0d %s start", i, c, kname[k]), st, exp_q[idx].start);
      check($sformatf("u%0d ch%0d %s len", i, c, kname[k]), ln, exp_q[idx].len);
      exp_q.delete(idx);
    end
  endtask

  // Monitor: measures each pulse and checks per-cycle invariants.
  initial begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) begin
          prev_v[i][c][k] = 1'b0;
          st_v[i][c][k]   = 0;
        end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d any_or", i), 32'(any_w[i]), 32'(|mr_w[i]));
        check($sformatf("u%0d mr_dr_excl", i), 32'(mr_w[i] & dr_w[i]), 32'd0);
        for (int c = 0; c < 4; c++)
          for (int k = 0; k < 4; k++) begin
            logic [3:0] v;
            v = sig(i, k);
            if (v[c] && !prev_v[i][c][k]) st_v[i][c][k] = cyc;
            if (!v[c] && prev_v[i][c][k]) retire(i, c, k, st_v[i][c][k], cyc - st_v[i][c][k]);
            prev_v[i][c][k] = v[c];
          end
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s u%0d mass_reset", tag, i), 32'(mr_w[i]), 32'd0);
      check($sformatf("%s u%0d diode_req", tag, i), 32'(dr_w[i]), 32'd0);
      check($sformatf("%s u%0d done", tag, i), 32'(done_w[i]), 32'd0);
      check($sformatf("%s u%0d busy", tag, i), 32'(busy_w[i]), 32'd0);
      check($sformatf("%s u%0d overrun", tag, i), 32'(ovr_w[i]), 32'd0);
      check($sformatf("%s u%0d any", tag, i), 32'(any_w[i]), 32'd0);
    end
  endtask

  initial begin
    int k;
    reset = 1'b1; req0 = '0; req1 = '0; clr_ovr = 1'b0;
    rst_len = '0; gap_len = '0; pulse_len = '0;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("after_release");

    // Nominal sequence; length inputs change right after acceptance.
    rst_len = 9'd3; gap_len = 9'd2; pulse_len = 9'd40;
    req0 = 4'b0001; k = cyc;
    push(0, 0, K_MR, k + 1, 3);   push(0, 0, K_DR, k + 6, 40);
    push(0, 0, K_DONE, k + 46, 1); push(0, 0, K_BUSY, k + 1, 45);
    @(negedge clk);
    req0 = '0; rst_len = 9'd7; gap_len = 9'd9; pulse_len = 9'd1;
    wait_until(k + 50);

    // All lengths zero: one reset cycle, then done.
    rst_len = '0; gap_len = '0; pulse_len = '0;
    req0 = 4'b0010; k = cyc;
    push(0, 1, K_MR, k + 1, 1); push(0, 1, K_DONE, k + 2, 1); push(0, 1, K_BUSY, k + 1, 1);
    @(negedge clk);
    req0 = '0;
    wait_until(k + 6);

    // Overrun while busy, then clear racing a fresh overrun.
    rst_len = 9'd3; gap_len = 9'd2; pulse_len = 9'd40;
    req0 = 4'b0100; k = cyc;
    push(0, 2, K_MR, k + 1, 3);   push(0, 2, K_DR, k + 6, 40);
    push(0, 2, K_DONE, k + 46, 1); push(0, 2, K_BUSY, k + 1, 45);
    @(negedge clk);
    req0 = '0;
    wait_until(k + 5);
    check("ovr before", 32'(ovr_w[0][2]), 32'd0);
    req0 = 4'b0100;
    @(negedge clk);
    req0 = '0;
    check("ovr set", 32'(ovr_w[0][2]), 32'd1);
    wait_until(k + 10);
    req0 = 4'b0100; clr_ovr = 1'b1;
    @(negedge clk);
    req0 = '0; clr_ovr = 1'b0;
    check("ovr clr vs set", 32'(ovr_w[0][2]), 32'd1);
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("ovr cleared", 32'(ovr_w[0][2]), 32'd0);
    wait_until(k + 50);

    // Retrigger: request held ten cycles keeps mass reset high.
    rst_len = 9'd2; gap_len = 9'd1; pulse_len = 9'd3;
    req1 = 4'b0001; k = cyc;
    push(1, 0, K_MR, k + 1, 11);  push(1, 0, K_DR, k + 13, 3);
    push(1, 0, K_DONE, k + 16, 1); push(1, 0, K_BUSY, k + 1, 15);
    repeat (10) @(negedge clk);
    req1 = '0;
    wait_until(k + 20);

    // Two channels three cycles apart with different lengths.
    rst_len = 9'd4; gap_len = 9'd1; pulse_len = 9'd5;
    req0 = 4'b0001; k = cyc;
    push(0, 0, K_MR, k + 1, 4);   push(0, 0, K_DR, k + 6, 5);
    push(0, 0, K_DONE, k + 11, 1); push(0, 0, K_BUSY, k + 1, 10);
    @(negedge clk);
    req0 = '0; rst_len = 9'd2; gap_len = 9'd0; pulse_len = 9'd3;
    wait_until(k + 3);
    req0 = 4'b1000;
    push(0, 3, K_MR, k + 4, 2);   push(0, 3, K_DR, k + 6, 3);
    push(0, 3, K_DONE, k + 9, 1);  push(0, 3, K_BUSY, k + 4, 5);
    @(negedge clk);
    req0 = '0;
    wait_until(k + 16);

    // Longest reset pulse the counter can express.
    rst_len = 9'd511; gap_len = 9'd0; pulse_len = 9'd1;
    req1 = 4'b1000; k = cyc;
    push(1, 3, K_MR, k + 1, 511);  push(1, 3, K_DR, k + 512, 1);
    push(1, 3, K_DONE, k + 513, 1); push(1, 3, K_BUSY, k + 1, 512);
    @(negedge clk);
    req1 = '0;
    wait_until(k + 518);

    // Asynchronous reset in the middle of a diode pulse.
    rst_len = 9'd1; gap_len = 9'd0; pulse_len = 9'd20;
    req0 = 4'b0010; k = cyc;
    push(0, 1, K_MR, k + 1, 1); push(0, 1, K_DR, k + 2, 5); push(0, 1, K_BUSY, k + 1, 6);
    @(negedge clk);
    req0 = '0;
    wait_until(k + 6);
    check("dr before abort", 32'(dr_w[0][1]), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // First request after release is accepted with the normal latency.
    rst_len = '0; gap_len = '0; pulse_len = '0;
    req0 = 4'b0010; k = cyc;
    push(0, 1, K_MR, k + 1, 1); push(0, 1, K_DONE, k + 2, 1); push(0, 1, K_BUSY, k + 1, 1);
    @(negedge clk);
    req0 = '0;
    wait_until(k + 8);

    check("retrig never overruns", 32'(ovr_w[1]), 32'd0);
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
